// File: rtl/wb_queue_if.sv
// Write-back queue bus: producer push channel, register-file write port,
// and decode-stage hazard lookup. The forward-value signals exist only
// when WBQ_BYPASS_EN is defined.
interface wb_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Producer push channel
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_addr;
    logic             in_link;
    logic [31:0]      in_data;

    // Register-file write port
    logic             rf_we;
    logic [4:0]       rf_addr;
    logic [31:0]      rf_data;
    logic             rf_stall;

    // Decode-stage hazard lookup
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic             rs_pending;
    logic             rt_pending;
`ifdef WBQ_BYPASS_EN
    logic [31:0]      rs_fwd;
    logic [31:0]      rt_fwd;
`endif

    logic [CNT_W-1:0] count;

`ifdef WBQ_BYPASS_EN
    modport master (
        output in_valid, in_addr, in_link, in_data, rf_stall, rs, rt,
        input  in_ready, rf_we, rf_addr, rf_data, rs_pending, rt_pending,
               rs_fwd, rt_fwd, count
    );
    modport slave (
        input  in_valid, in_addr, in_link, in_data, rf_stall, rs, rt,
        output in_ready, rf_we, rf_addr, rf_data, rs_pending, rt_pending,
               rs_fwd, rt_fwd, count
    );
`else
    modport master (
        output in_valid, in_addr, in_link, in_data, rf_stall, rs, rt,
        input  in_ready, rf_we, rf_addr, rf_data, rs_pending, rt_pending, count
    );
    modport slave (
        input  in_valid, in_addr, in_link, in_data, rf_stall, rs, rt,
        output in_ready, rf_we, rf_addr, rf_data, rs_pending, rt_pending, count
    );
`endif
endinterface

// File: rtl/wb_queue.sv
// wb_queue: in-order write-back queue between a result producer and the
// register-file write port, with decode-stage pending-write lookup.
// Optional feature macro: WBQ_BYPASS_EN adds youngest-match data forwarding
// on rs_fwd/rt_fwd; without it the consumer stalls on the pending flags.
module wb_queue #(
    parameter int         DEPTH          = 4,
    parameter logic [4:0] RETURN_ADDRESS = 5'd31
) (
    input logic       clock,
    input logic       reset,
    wb_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [4:0]       addr_mem_q [DEPTH];
    logic [31:0]      data_mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [4:0]       eff_addr;
    logic             push;
    logic             store;
    logic             pop;
    logic [PTR_W-1:0] idx;
    logic             live;

    // Link results always target the return-address register.
    assign eff_addr    = bus.in_link ? RETURN_ADDRESS : bus.in_addr;
    assign bus.in_ready = (count_q != CNT_W'(DEPTH));
    assign push        = bus.in_valid && bus.in_ready;
    // Writes to register 0 are accepted and discarded.
    assign store       = push && (eff_addr != 5'd0);
    assign bus.rf_we   = (count_q != '0);
    assign pop         = bus.rf_we && !bus.rf_stall;
    assign bus.rf_addr = bus.rf_we ? addr_mem_q[rd_ptr_q] : 5'd0;
    assign bus.rf_data = bus.rf_we ? data_mem_q[rd_ptr_q] : 32'd0;
    assign bus.count   = count_q;

    // Next-state for pointers, per-entry valid bits and occupancy count.
    always_comb begin
        // NOTE: every variable gets its default before any branch so no latch is inferred.
        valid_d  = valid_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end
        if (store) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
        case ({store, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset drops every queued entry at once.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            valid_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage written on a storing push.
    always_ff @(posedge clock) begin
        // NOTE: payload storage is not reset; the valid bits alone decide what is live.
        if (store) begin
            addr_mem_q[wr_ptr_q] <= eff_addr;
            data_mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    // Hazard lookup, scanning oldest to youngest so the last hit is the youngest.
    always_comb begin
        bus.rs_pending = 1'b0;
        bus.rt_pending = 1'b0;
`ifdef WBQ_BYPASS_EN
        bus.rs_fwd     = 32'd0;
        bus.rt_fwd     = 32'd0;
`endif
        idx  = '0;
        live = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            idx  = rd_ptr_q + PTR_W'(i);
            // The head leaving this cycle no longer holds a pending write.
            live = valid_q[idx] && !(pop && (idx == rd_ptr_q));
            if (live && (bus.rs != 5'd0) && (addr_mem_q[idx] == bus.rs)) begin
                bus.rs_pending = 1'b1;
`ifdef WBQ_BYPASS_EN
                bus.rs_fwd     = data_mem_q[idx];
`endif
            end
            if (live && (bus.rt != 5'd0) && (addr_mem_q[idx] == bus.rt)) begin
                bus.rt_pending = 1'b1;
`ifdef WBQ_BYPASS_EN
                bus.rt_fwd     = data_mem_q[idx];
`endif
            end
        end
    end
endmodule
